// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller: serves 32-bit instruction fetches and 1/2/4-byte
// data loads/stores as sequential 8-bit RAM accesses. Data requests win
// arbitration; each completed transaction returns a one-cycle done pulse.
module mem_ctrl #(
   parameter int unsigned RAM_ADDR_W = 17
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rdy,
   input  logic                  inst_needed,
   input  logic [31:0]           inst_addr,
   output logic                  inst_available,
   output logic [31:0]           inst_from_mem,
   input  logic                  data_req,
   input  logic                  data_we,
   input  logic [1:0]            data_len,
   input  logic [31:0]           data_addr,
   input  logic [31:0]           data_wdata,
   output logic                  data_done,
   output logic [31:0]           data_rdata,
   input  logic [7:0]            mem_din,
   output logic [7:0]            mem_dout,
   output logic [RAM_ADDR_W-1:0] mem_a,
   output logic                  mem_wr
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t                state, state_n;
   logic [2:0]            cnt, cnt_n;
   logic [2:0]            nbytes, nbytes_n;
   logic                  fetch, fetch_n;
   logic [31:0]           addr, addr_n;
   logic [31:0]           wdata, wdata_n;
   logic [31:0]           rbuf, rbuf_n;
   logic                  inst_available_n;
   logic [31:0]           inst_from_mem_n;
   logic                  data_done_n;
   logic [31:0]           data_rdata_n;
   logic [7:0]            mem_dout_n;
   logic [RAM_ADDR_W-1:0] mem_a_n;
   logic                  mem_wr_n;
   logic [1:0]            ridx;
   logic [1:0]            widx;

   // Next-state and next-output computation; every output is registered, so
   // the values for cycle k+1 are prepared here during cycle k.
   always_comb begin
      state_n          = state;
      cnt_n            = cnt;
      nbytes_n         = nbytes;
      fetch_n          = fetch;
      addr_n           = addr;
      wdata_n          = wdata;
      rbuf_n           = rbuf;
      inst_available_n = 1'b0;
      inst_from_mem_n  = inst_from_mem;
      data_done_n      = 1'b0;
      data_rdata_n     = data_rdata;
      mem_dout_n       = mem_dout;
      mem_a_n          = mem_a;
      mem_wr_n         = 1'b0;
      ridx             = 2'(cnt - 3'd1);
      widx             = 2'(cnt + 3'd1);

      unique case (state)
         IDLE: begin
            if (data_req) begin
               addr_n   = data_addr;
               nbytes_n = (data_len == 2'd0) ? 3'd1 : (data_len == 2'd1) ? 3'd2 : 3'd4;
               fetch_n  = 1'b0;
               wdata_n  = data_wdata;
               rbuf_n   = '0;
               cnt_n    = '0;
               mem_a_n  = data_addr[RAM_ADDR_W-1:0];
               if (data_we) begin
                  mem_dout_n = data_wdata[7:0];
                  mem_wr_n   = 1'b1;
                  state_n    = WRITE;
               end else begin
                  state_n    = READ;
               end
            end else if (inst_needed) begin
               addr_n   = inst_addr;
               nbytes_n = 3'd4;
               fetch_n  = 1'b1;
               rbuf_n   = '0;
               cnt_n    = '0;
               mem_a_n  = inst_addr[RAM_ADDR_W-1:0];
               state_n  = READ;
            end
         end

         READ: begin
            if (fetch && !inst_needed) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else begin
               // cnt counts READ cycles: issue addresses while cnt+1 < N,
               // capture the byte addressed one cycle earlier once cnt >= 1.
               cnt_n = cnt + 3'd1;
               if ((cnt + 3'd1) < nbytes)
                  mem_a_n = RAM_ADDR_W'(addr + 32'(cnt) + 32'd1);
               if (cnt != 3'd0)
                  rbuf_n[{ridx, 3'b000} +: 8] = mem_din;
               if (cnt == nbytes) begin
                  state_n = DONE;
                  cnt_n   = '0;
                  if (fetch) begin
                     inst_available_n = 1'b1;
                     inst_from_mem_n  = rbuf_n;
                  end else begin
                     data_done_n      = 1'b1;
                     data_rdata_n     = rbuf_n;
                  end
               end
            end
         end

         WRITE: begin
            if ((cnt + 3'd1) < nbytes) begin
               cnt_n      = cnt + 3'd1;
               mem_a_n    = RAM_ADDR_W'(addr + 32'(cnt) + 32'd1);
               mem_dout_n = wdata[{widx, 3'b000} +: 8];
               mem_wr_n   = 1'b1;
            end else begin
               data_done_n = 1'b1;
               cnt_n       = '0;
               state_n     = DONE;
            end
         end

         DONE: begin
            state_n = IDLE;
         end

         default: state_n = IDLE;
      endcase
   end

   // State and output registers; rdy low freezes everything, done pulses included.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         cnt            <= '0;
         nbytes         <= '0;
         fetch          <= 1'b0;
         addr           <= '0;
         wdata          <= '0;
         rbuf           <= '0;
         inst_available <= 1'b0;
         inst_from_mem  <= '0;
         data_done      <= 1'b0;
         data_rdata     <= '0;
         mem_dout       <= '0;
         mem_a          <= '0;
         mem_wr         <= 1'b0;
      end else if (rdy) begin
         state          <= state_n;
         cnt            <= cnt_n;
         nbytes         <= nbytes_n;
         fetch          <= fetch_n;
         addr           <= addr_n;
         wdata          <= wdata_n;
         rbuf           <= rbuf_n;
         inst_available <= inst_available_n;
         inst_from_mem  <= inst_from_mem_n;
         data_done      <= data_done_n;
         data_rdata     <= data_rdata_n;
         mem_dout       <= mem_dout_n;
         mem_a          <= mem_a_n;
         mem_wr         <= mem_wr_n;
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a byte-array reference memory produces the
// expected fetch/load words at issue time; a monitor pops them on done pulses.
module tb_mem_ctrl;

   localparam int unsigned AW   = 17;
   localparam logic [31:0] MASK = 32'h0001_FFFF;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          rdy = 1'b1;
   logic          inst_needed = 1'b0;
   logic [31:0]   inst_addr = '0;
   logic          inst_available;
   logic [31:0]   inst_from_mem;
   logic          data_req = 1'b0;
   logic          data_we = 1'b0;
   logic [1:0]    data_len = '0;
   logic [31:0]   data_addr = '0;
   logic [31:0]   data_wdata = '0;
   logic          data_done;
   logic [31:0]   data_rdata;
   logic [7:0]    mem_din = '0;
   logic [7:0]    mem_dout;
   logic [AW-1:0] mem_a;
   logic          mem_wr;

   mem_ctrl #(.RAM_ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .inst_needed(inst_needed), .inst_addr(inst_addr),
      .inst_available(inst_available), .inst_from_mem(inst_from_mem),
      .data_req(data_req), .data_we(data_we), .data_len(data_len),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_done(data_done), .data_rdata(data_rdata),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
   );

   always #5 clk = ~clk;

   // Synchronous byte RAM; frozen along with the controller when rdy is low.
   logic [7:0] ram [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (rdy) begin
         if (mem_wr) ram[mem_a] <= mem_dout;
         mem_din <= ram[mem_a];
      end
   end

   typedef struct { bit fetch; logic [31:0] data; } exp_t;
   exp_t        sb[$];
   logic [7:0]  model_mem [int unsigned];
   logic [31:0] last_rdata = '0;
   int          compared = 0;
   int          mismatched = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] mget(input logic [31:0] a);
      int unsigned k = a & MASK;
      return model_mem.exists(k) ? model_mem[k] : 8'h00;
   endfunction

   function automatic int nb(input logic [1:0] len);
      return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
      logic [31:0] r = '0;
      for (int i = 0; i < n; i++) r[8*i +: 8] = mget(a + 32'(i));
      return r;
   endfunction

   function automatic logic [31:0] rand_addr();
      logic [31:0] hi = $urandom & 32'hFFFE_0000;
      if ($urandom_range(0, 3) == 0) return hi | (32'h0001_FFFC + $urandom_range(0, 3));
      return hi | $urandom_range(0, 63);
   endfunction

   task automatic push_data(input bit we, input logic [1:0] len, input logic [31:0] a,
                            input logic [31:0] wd);
      exp_t e;
      e.fetch = 1'b0;
      if (we) begin
         for (int i = 0; i < nb(len); i++) model_mem[(a + 32'(i)) & MASK] = wd[8*i +: 8];
         e.data = last_rdata;
      end else begin
         e.data = model_read(a, nb(len));
         last_rdata = e.data;
      end
      sb.push_back(e);
   endtask

   task automatic push_fetch(input logic [31:0] a);
      exp_t e;
      e.fetch = 1'b1;
      e.data  = model_read(a, 4);
      sb.push_back(e);
   endtask

   // Monitor: every done pulse consumes the oldest expectation for that port.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && rdy) begin
         if (inst_available) begin
            if (sb.size() == 0 || !sb[0].fetch) begin
               compared++; mismatched++;
               $display("FAIL inst_pulse: got unexpected inst_available expected none at %0t", $time);
            end else begin
               e = sb.pop_front();
               check("inst_from_mem", inst_from_mem, e.data);
            end
         end
         if (data_done) begin
            if (sb.size() == 0 || sb[0].fetch) begin
               compared++; mismatched++;
               $display("FAIL data_pulse: got unexpected data_done expected none at %0t", $time);
            end else begin
               e = sb.pop_front();
               check("data_rdata", data_rdata, e.data);
            end
         end
      end
   end

   // mode: 0 plain, 1 timed with bus trace, 2 timed with rdy low in cycles 2..4, 3 random rdy
   task automatic run_txn(input bit dd, input bit we, input logic [1:0] len,
                          input logic [31:0] da, input logic [31:0] wd,
                          input bit df, input logic [31:0] fa, input int mode);
      int cyc = 0, dlat = 0, flat = 0, n, dexp;
      bit dgot = !dd, fgot = !df;
      logic [31:0] a, ta;
      if (dd) push_data(we, len, da, wd);
      if (df) push_fetch(fa);
      n    = dd ? nb(len) : 4;
      a    = dd ? da : fa;
      dexp = (dd && we) ? n + 1 : n + 2;
      data_req = dd; data_we = we; data_len = len; data_addr = da; data_wdata = wd;
      inst_needed = df; inst_addr = fa;
      while (!(dgot && fgot) && cyc < 400) begin
         @(posedge clk); #1; cyc++;
         if (mode == 2) rdy = !(cyc >= 2 && cyc <= 4);
         if (mode == 3) rdy = ($urandom_range(0, 4) != 0);
         if (mode == 1 && !(dd && df) && cyc <= n) begin
            ta = a + 32'(cyc) - 32'd1;
            check("mem_a", 32'(mem_a), ta & MASK);
            check("mem_wr", 32'(mem_wr), 32'(dd && we));
            if (dd && we) check("mem_dout", 32'(mem_dout), 32'(wd[8*(cyc-1) +: 8]));
         end
         if (mode == 1 && dd && we && cyc == n + 1) check("mem_wr_end", 32'(mem_wr), 32'd0);
         if (mode == 2 && cyc >= 2 && cyc <= 5) check("mem_a_stall", 32'(mem_a), (a + 32'd1) & MASK);
         if (data_done && !dgot) begin dgot = 1; dlat = cyc; data_req = 1'b0; end
         if (inst_available && !fgot) begin fgot = 1; flat = cyc; inst_needed = 1'b0; end
      end
      rdy = 1'b1;
      if (!(dgot && fgot)) begin
         compared++; mismatched++;
         $display("FAIL timeout: got no done after %0d cycles expected done", cyc);
         data_req = 1'b0; inst_needed = 1'b0;
      end else if (mode == 1 || mode == 2) begin
         if (dd) check("data_latency", dlat, dexp + (mode == 2 ? 3 : 0));
         if (df) check("inst_latency", flat, (dd ? dexp + 1 : 0) + 6 + (mode == 2 ? 3 : 0));
      end
      @(posedge clk); #1;
   endtask

   initial begin
      int cyc;
      for (int i = 0; i < (1 << AW); i++) ram[i] = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs",
            {inst_from_mem[31:1], inst_available} | data_rdata |
            {data_done, mem_wr, 5'd0, mem_a, mem_dout},
            32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed: fetch of a known word with bus trace and latency.
      ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
      model_mem[32'h100] = 8'h13; model_mem[32'h101] = 8'h05;
      model_mem[32'h102] = 8'h00; model_mem[32'h103] = 8'h00;
      run_txn(0, 0, 2'd0, 32'h0, 32'h0, 1, 32'h100, 1);

      // Directed: word store, then half load of its upper half.
      run_txn(1, 1, 2'd2, 32'h200, 32'hDEAD_BEEF, 0, 32'h0, 1);
      run_txn(1, 0, 2'd1, 32'h202, 32'h0, 0, 32'h0, 1);
      check("half_load_direct", data_rdata, 32'h0000_DEAD);

      // Directed: both requesters together, data first.
      run_txn(1, 0, 2'd2, 32'h200, 32'h0, 1, 32'h100, 1);
      run_txn(1, 1, 2'd0, 32'h1_FFFF, 32'h0000_00A5, 1, 32'hFFFF_FFFE, 1);

      // Directed: fetch aborted in cycle 3, data load accepted right after.
      inst_needed = 1'b1; inst_addr = 32'h300;
      repeat (3) begin @(posedge clk); #1; end
      inst_needed = 1'b0;
      @(posedge clk); #1;
      push_data(0, 2'd2, 32'h100, 32'h0);
      data_req = 1'b1; data_we = 1'b0; data_len = 2'd2; data_addr = 32'h100;
      cyc = 0;
      while (!data_done && cyc < 50) begin @(posedge clk); #1; cyc++; end
      data_req = 1'b0;
      check("abort_then_load_latency", cyc, 6);
      @(posedge clk); #1;

      // Directed: rdy low three cycles during a word load.
      run_txn(1, 0, 2'd2, 32'h200, 32'h0, 0, 32'h0, 2);

      // Directed: reset during a store leaves the bytes already written.
      data_req = 1'b1; data_we = 1'b1; data_len = 2'd2; data_addr = 32'h400;
      data_wdata = 32'h1234_5678;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      data_req = 1'b0;
      @(posedge clk); #1;
      check("rst_mem_wr", 32'(mem_wr), 32'd0);
      check("rst_mem_a", 32'(mem_a), 32'd0);
      check("rst_data_rdata", data_rdata, 32'd0);
      rst = 1'b0;
      model_mem[32'h400] = 8'h78; model_mem[32'h401] = 8'h56; model_mem[32'h402] = 8'h34;
      last_rdata = '0;
      @(posedge clk); #1;
      run_txn(1, 0, 2'd2, 32'h400, 32'h0, 0, 32'h0, 1);

      // Random traffic with random stalls.
      for (int i = 0; i < 150; i++) begin
         int unsigned kind = $urandom_range(0, 2);
         run_txn(kind != 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                 rand_addr(), $urandom, kind != 1, rand_addr(), 3);
      end

      repeat (5) @(posedge clk);
      #1;
      check("scoreboard_empty", sb.size(), 0);
      foreach (model_mem[k]) check("ram_contents", 32'(ram[k]), 32'(model_mem[k]));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
